// File: rtl/load_store_unit.sv
// Load/store unit: turns the ALU address into a handshaked data-memory access,
// stalls the core while it runs, and returns the extended load value.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        access;
    logic        is_store;
    logic        f3_ok;
    logic        aligned;
    logic        launch;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign access   = MemRead | MemWrite;
    assign is_store = MemWrite;

    // Stores have no unsigned variants, so 100/101 are only legal for loads.
    always_comb begin
        f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~is_store;
            default:                f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = ~ALUResult[0];
            2'b10:   aligned = (ALUResult[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign launch      = (state == IDLE) && access && f3_ok && aligned;
    assign MisalignErr = (state == IDLE) && access && !(f3_ok && aligned);
    assign Stall       = launch || (state == REQ);

    always_comb begin
        st_be   = 4'b1111;
        st_data = WriteData;
        case (funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << ALUResult[1:0];
                st_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                st_be   = ALUResult[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteData[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = WriteData;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_val  = mem_rdata;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 16'h0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            ReadData  <= 32'h0;
            BusErr    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            BusErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {ALUResult[31:2], 2'b00};
                        mem_be    <= is_store ? st_be : 4'b1111;
                        mem_wdata <= is_store ? st_data : 32'h0;
                        off_q     <= ALUResult[1:0];
                        f3_q      <= funct3;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadData <= ld_val;
                        end
                    end else if (cnt == LAST) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        ReadData <= 32'h0;
                        BusErr   <= 1'b1;
                        cnt      <= cnt + 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= 16'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit; expected write-back results go
// through a scoreboard queue and are checked when the access reaches DONE.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .funct3(funct3),
        .ReadData(ReadData),
        .Stall(Stall),
        .MisalignErr(MisalignErr),
        .BusErr(BusErr),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rd = 32'h0;

    int          req_n;
    int          stall_n;
    logic        stable;
    logic        done;
    logic        o_berr;
    logic        o_stall_done;
    logic        after_req;
    logic        after_berr;
    logic [31:0] o_rd;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  be0;
    logic        we0;

    // Drives one access and records what the DUT did; tests do the checking.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata,
                              input int delay);
        @(negedge clk);
        MemRead = rd;
        MemWrite = wr;
        funct3 = f3;
        ALUResult = addr;
        WriteData = wd;
        mem_ready = 1'b0;
        #1;
        req_n = 0;
        stall_n = Stall ? 1 : 0;
        stable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                if (req_n == 0) begin
                    a0 = mem_addr;
                    be0 = mem_be;
                    w0 = mem_wdata;
                    we0 = mem_we;
                end else if (mem_addr !== a0 || mem_be !== be0 ||
                             mem_wdata !== w0 || mem_we !== we0) begin
                    stable = 1'b0;
                end
                req_n++;
                if (Stall) stall_n++;
                mem_ready = (req_n > delay);
                mem_rdata = rdata;
            end else begin
                mem_ready = 1'b0;
                o_rd = ReadData;
                o_berr = BusErr;
                o_stall_done = Stall;
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        #1;
        after_req = mem_req;
        after_berr = BusErr;
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({mem_req, mem_we, mem_be, BusErr, Stall} !== 8'h0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_be, BusErr, Stall});
        end
        total++;
        if (ReadData !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd: got %h want 0", ReadData);
        end
        total++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus: got %h %h want 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        MemRead = 1'b1;
        funct3 = 3'b010;
        ALUResult = 32'h500;
        @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL midreq_pre: mem_req got %b want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL midreq_drop: mem_req got %b want 0", mem_req);
        end
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({Stall, mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL midreq_idle: stall/req got %b want 00", {Stall, mem_req});
        end
        total++;
        if (ReadData !== 32'h0) begin
            bad++;
            $display("FAIL midreq_rd: got %h want 0", ReadData);
        end
    endtask

    task automatic test_lw();
        sb.push_back('{rd: 32'hDEADBEEF, berr: 1'b0});
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        last_rd = 32'hDEADBEEF;
        e = sb.pop_front();
        total++;
        if (!done || o_rd !== e.rd || o_berr !== e.berr) begin
            bad++;
            $display("FAIL lw_result: got done=%b rd=%h berr=%b want rd=%h berr=%b",
                     done, o_rd, o_berr, e.rd, e.berr);
        end
        total++;
        if (a0 !== 32'h100 || be0 !== 4'hF || we0 !== 1'b0) begin
            bad++;
            $display("FAIL lw_bus: got addr=%h be=%b we=%b want 100 1111 0", a0, be0, we0);
        end
        total++;
        if (stall_n != 2 || req_n != 1 || o_stall_done !== 1'b0) begin
            bad++;
            $display("FAIL lw_timing: got stall=%0d req=%0d dstall=%b want 2 1 0",
                     stall_n, req_n, o_stall_done);
        end
        total++;
        if (after_req !== 1'b0) begin
            bad++;
            $display("FAIL lw_no_relaunch: mem_req got %b want 0", after_req);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s[3];
        logic [31:0] adr[3];
        logic [31:0] exp_v[3];
        f3s = '{3'b000, 3'b100, 3'b101};
        adr = '{32'h103, 32'h103, 32'h102};
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF};
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{rd: exp_v[k], berr: 1'b0});
            run_access(1'b1, 1'b0, f3s[k], adr[k], 32'h0, 32'h80FF1234, k);
            last_rd = exp_v[k];
            e = sb.pop_front();
            total++;
            if (!done || o_rd !== e.rd || o_berr !== e.berr || a0 !== 32'h100) begin
                bad++;
                $display("FAIL load_ext_%0d: got rd=%h addr=%h want rd=%h addr=100",
                         k, o_rd, a0, e.rd);
            end
        end
    endtask

    task automatic test_sb();
        sb.push_back('{rd: last_rd, berr: 1'b0});
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 3);
        e = sb.pop_front();
        total++;
        if (!done || o_rd !== e.rd || o_berr !== e.berr) begin
            bad++;
            $display("FAIL sb_result: got rd=%h berr=%b want rd=%h berr=%b",
                     o_rd, o_berr, e.rd, e.berr);
        end
        total++;
        if (a0 !== 32'h200 || be0 !== 4'b0010 || w0 !== 32'hABABABAB || we0 !== 1'b1) begin
            bad++;
            $display("FAIL sb_bus: got %h %b %h %b want 200 0010 ababab 1",
                     a0, be0, w0, we0);
        end
        total++;
        if (!stable || req_n != 4) begin
            bad++;
            $display("FAIL sb_wait: got stable=%b req=%0d want 1 4", stable, req_n);
        end
    endtask

    task automatic test_misalign();
        logic        wr[3];
        logic [2:0]  f3s[3];
        logic [31:0] adr[3];
        wr = '{1'b1, 1'b0, 1'b1};
        f3s = '{3'b001, 3'b010, 3'b100};
        adr = '{32'h301, 32'h402, 32'h400};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            MemRead = ~wr[k];
            MemWrite = wr[k];
            funct3 = f3s[k];
            ALUResult = adr[k];
            #1;
            total++;
            if ({MisalignErr, Stall, mem_req} !== 3'b100) begin
                bad++;
                $display("FAIL misalign_%0d: got err/stall/req=%b want 100",
                         k, {MisalignErr, Stall, mem_req});
            end
            @(negedge clk);
            #1;
            total++;
            if (mem_req !== 1'b0) begin
                bad++;
                $display("FAIL misalign_noreq_%0d: mem_req got %b want 0", k, mem_req);
            end
            MemRead = 1'b0;
            MemWrite = 1'b0;
        end
    endtask

    task automatic test_timeout();
        sb.push_back('{rd: 32'h0, berr: 1'b1});
        run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h12345678, 1000);
        last_rd = 32'h0;
        e = sb.pop_front();
        total++;
        if (!done || o_rd !== e.rd || o_berr !== e.berr) begin
            bad++;
            $display("FAIL timeout_result: got done=%b rd=%h berr=%b want rd=%h berr=%b",
                     done, o_rd, o_berr, e.rd, e.berr);
        end
        total++;
        if (req_n != 4) begin
            bad++;
            $display("FAIL timeout_len: req cycles got %0d want 4", req_n);
        end
        total++;
        if (after_berr !== 1'b0 || after_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: berr/req got %b%b want 00", after_berr, after_req);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{rd: last_rd, berr: 1'b0});
        run_access(1'b1, 1'b1, 3'b001, 32'h206, 32'h1234CDEF, 32'h0, 1);
        e = sb.pop_front();
        total++;
        if (!done || o_rd !== e.rd || be0 !== 4'b1100 ||
            w0 !== 32'hCDEFCDEF || we0 !== 1'b1) begin
            bad++;
            $display("FAIL sh_both: got rd=%h be=%b wd=%h we=%b want rd=%h 1100 cdefcdef 1",
                     o_rd, be0, w0, we0, e.rd);
        end
        sb.push_back('{rd: 32'hFFFF8001, berr: 1'b0});
        run_access(1'b1, 1'b0, 3'b001, 32'h206, 32'h0, 32'h80015555, 0);
        last_rd = 32'hFFFF8001;
        e = sb.pop_front();
        total++;
        if (!done || o_rd !== e.rd || o_berr !== e.berr) begin
            bad++;
            $display("FAIL lh_result: got rd=%h want %h", o_rd, e.rd);
        end
    endtask

    initial begin
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset_mid_req();
        test_lw();
        test_load_ext();
        test_sb();
        test_misalign();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the RISC-V datapath.
- Takes the ALU result as the effective address for loads and stores.
- Runs a handshaked access to a data memory that may take several cycles. Stalls the core until the access completes.
- Returns a sign- or zero-extended load value for write-back, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum REQ cycles waiting for mem_ready before a bus error is declared (1..65535).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ALUResult  input  32  effective byte address from the ALU
- WriteData  input  32  store data (rs2)
- MemRead  input  1  current instruction is a load
- MemWrite  input  1  current instruction is a store
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ReadData  output  32  extended load result, valid in DONE
- Stall  output  1  freeze PC and pipeline state while high
- MisalignErr  output  1  one-cycle pulse: misaligned or illegal access
- BusErr  output  1  one-cycle pulse in DONE when the access timed out
- mem_req  output  1  memory request, held until accepted
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-aligned store data
- mem_ready  input  1  memory completes the request this cycle
- mem_rdata  input  32  read word, valid when mem_ready=1

Behaviour:
- Reset state, while rst_n=0: IDLE. ReadData=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, BusErr=0, timeout counter=0.
- Reset asserted mid-access drops mem_req immediately (asynchronous). No completion is reported.
- States are IDLE, REQ and DONE.
- IDLE, access = MemRead|MemWrite. If MemRead and MemWrite are both high, treat the access as a store.
  - Legal and aligned access: Stall=1 combinationally. Latch address, byte offset, funct3, we and lane data. Go to REQ.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 (011, 110, 111; stores also reject 100 and 101): MisalignErr=1 combinationally that cycle, Stall=0, no request, stay IDLE.
- REQ: mem_req=1 and Stall=1.
  - The address, enables and data outputs stay stable until mem_ready.
  - On mem_ready=1: capture the extended load value into ReadData (loads only) and go to DONE.
  - The counter increments each REQ cycle without mem_ready. When the counter reaches TIMEOUT, drop mem_req, set ReadData=0 and BusErr, and go to DONE.
- DONE: Stall=0, mem_req=0. ReadData is valid for the write-back that commits this cycle. BusErr pulses here if the access timed out. Always return to IDLE next cycle, clearing the counter. DONE never launches a new access, even though MemRead/MemWrite are still high.
- Minimum latency: a memory instruction occupies 3 cycles (IDLE detect, REQ with mem_ready, DONE).
- Byte enables by offset o = addr[1:0]:
  - B: 1<<o
  - H: 0011 (o=0) or 1100 (o=2)
  - W: 1111
- Store data: B replicates WriteData[7:0] into all 4 lanes. H replicates [15:0] twice. W passes through.
- Load extraction:
  - B/BU select byte o; H/HU select halfword o[1].
  - B and H sign-extend; BU and HU zero-extend.
- Loads drive mem_we=0 and mem_be=1111 regardless of size; the extraction happens locally.
- ReadData holds its last value outside DONE. Stores leave ReadData unchanged.

Test Plan:
- Reset mid-REQ: assert rst_n=0 with mem_req=1 -> mem_req=0 in the same cycle without a clock edge, state IDLE, Stall=0 after release.
- LW from 0x100, mem_ready on the first REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, Stall high 2 cycles, then ReadData=0xDEADBEEF in DONE with Stall=0.
- LB from 0x103 with mem_rdata=0x80FF1234 -> ReadData=0xFFFFFF80. LBU from the same address -> 0x00000080. LHU from 0x102 -> 0x000080FF.
- SB to 0x201 with WriteData=0x000000AB, mem_ready delayed 3 cycles -> mem_addr=0x200, mem_be=0010, mem_wdata=0xABABABAB, mem_we=1. Request lines stay stable across the wait, then DONE.
- SH to 0x301 -> MisalignErr pulse, Stall=0, mem_req never asserted. LW to 0x402 gives the same result.
- TIMEOUT=4 and mem_ready held at 0 -> mem_req high 4 cycles, then DONE with BusErr=1 and ReadData=0, then IDLE.
